// File: rtl/game_round_sequencer.sv
// Round-level sequencer: countdown, play, pause, respawn and game over.
// Owns lives and score, and emits a frame-locked step pulse during play.
module game_round_sequencer #(
    parameter int LIVES            = 3,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int RESPAWN_FRAMES   = 60,
    parameter int TICK_DIV         = 4,
    parameter int SCORE_W          = 16
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               vsync,
    input  logic               collision,
    input  logic               point,
    output logic [2:0]         state,
    output logic               gameon,
    output logic               freeze,
    output logic               step,
    output logic [3:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         frames_left
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSED    = 3'd3,
        S_RESPAWN   = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               start_q, pause_q, vsync_q;
    logic [3:0]         div_q, div_d;
    logic [3:0]         lives_d;
    logic [SCORE_W-1:0] score_d;
    logic [7:0]         frames_d;
    logic               step_d;

    // Rising edges are taken against the previous cycle's registered level.
    wire start_edge = start & ~start_q;
    wire pause_edge = pause & ~pause_q;
    wire tick       = vsync & ~vsync_q;

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d  = state_q;
        div_d    = div_q;
        lives_d  = lives;
        score_d  = score;
        frames_d = frames_left;
        step_d   = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    state_d  = S_COUNTDOWN;
                    lives_d  = 4'(LIVES);
                    score_d  = '0;
                    frames_d = 8'(COUNTDOWN_FRAMES);
                end
            end
            S_COUNTDOWN, S_RESPAWN: begin
                div_d = '0;
                if (tick) begin
                    if (frames_left == 8'd1) begin
                        state_d  = S_PLAY;
                        frames_d = '0;
                    end else begin
                        frames_d = frames_left - 8'd1;
                    end
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (div_q + 4'd1 == 4'(TICK_DIV)) begin
                        step_d = 1'b1;
                        div_d  = '0;
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end
                if (point && score != '1)
                    score_d = score + 1'b1;
                // Collision takes priority over a same-cycle pause edge.
                if (collision) begin
                    lives_d = lives - 4'd1;
                    if (lives == 4'd1) begin
                        state_d = S_OVER;
                    end else begin
                        state_d  = S_RESPAWN;
                        frames_d = 8'(RESPAWN_FRAMES);
                    end
                end else if (pause_edge) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (pause_edge)
                    state_d = S_PLAY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            vsync_q     <= 1'b0;
            div_q       <= '0;
            gameon      <= 1'b0;
            freeze      <= 1'b1;
            step        <= 1'b0;
            lives       <= 4'(LIVES);
            score       <= '0;
            frames_left <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            pause_q     <= pause;
            vsync_q     <= vsync;
            div_q       <= div_d;
            gameon      <= (state_d != S_IDLE) && (state_d != S_OVER);
            freeze      <= (state_d != S_PLAY);
            step        <= step_d;
            lives       <= lives_d;
            score       <= score_d;
            frames_left <= frames_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed bench for game_round_sequencer with hand-computed expectations.
module tb_game_round_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, pause = 1'b0, vsync = 1'b0;
    logic        collision = 1'b0, point = 1'b0;
    logic [2:0]  state;
    logic        gameon, freeze, step;
    logic [3:0]  lives;
    logic [15:0] score;
    logic [7:0]  frames_left;

    int total = 0;
    int bad = 0;
    int tick_no = 0;
    int step_count = 0;
    int wide_steps = 0;
    int step_ticks[$];
    logic step_prev = 1'b0;

    game_round_sequencer dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .pause(pause),
        .vsync(vsync), .collision(collision), .point(point), .state(state),
        .gameon(gameon), .freeze(freeze), .step(step), .lives(lives),
        .score(score), .frames_left(frames_left)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Step pulses are observed mid-cycle and logged with the frame they belong to.
    always @(negedge CLOCK_50) begin
        if (step) begin
            step_count++;
            step_ticks.push_back(tick_no);
            if (step_prev) wide_steps++;
        end
        step_prev = step;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic frame();
        tick_no++;
        vsync = 1'b1; cyc(2);
        vsync = 1'b0; cyc(2);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic press_start();
        start = 1'b1; cyc(2);
        start = 1'b0; cyc(2);
    endtask

    task automatic press_pause();
        pause = 1'b1; cyc(2);
        pause = 1'b0; cyc(2);
    endtask

    initial begin
        cyc(3);
        check("rst_state", state, 0);
        check("rst_gameon", gameon, 0);
        check("rst_freeze", freeze, 1);
        check("rst_lives", lives, 3);
        check("rst_frames", frames_left, 0);
        reset = 1'b0;
        cyc(2);

        // Countdown: 180 frames, pause ignored.
        press_start();
        check("cd_state", state, 1);
        check("cd_frames", frames_left, 180);
        check("cd_gameon", gameon, 1);
        frames(10);
        check("cd_frames10", frames_left, 170);
        press_pause();
        check("cd_pause_ignored", state, 1);
        frames(169);
        check("cd_frames179", frames_left, 1);
        check("cd_still", state, 1);
        frame();
        check("play_state", state, 2);
        check("play_gameon", gameon, 1);
        check("play_freeze", freeze, 0);
        check("play_score", score, 0);
        check("play_lives", lives, 3);
        check("play_frames", frames_left, 0);

        // Step pulses on ticks 4, 8, 12 of play.
        tick_no = 0; step_count = 0; wide_steps = 0; step_ticks.delete();
        press_start();
        check("start_ignored", state, 2);
        frames(12);
        check("step_count", step_count, 3);
        check("step_wide", wide_steps, 0);
        if (step_ticks.size() == 3) begin
            check("step_t0", step_ticks[0], 4);
            check("step_t1", step_ticks[1], 8);
            check("step_t2", step_ticks[2], 12);
        end else begin
            check("step_ticks_n", step_ticks.size(), 3);
        end

        // Pause with divider at 2; resume continues from 2.
        tick_no = 0; step_count = 0; step_ticks.delete();
        frames(2);
        press_pause();
        check("paused_state", state, 3);
        check("paused_freeze", freeze, 1);
        check("paused_gameon", gameon, 1);
        point = 1'b1; cyc(1); point = 1'b0; cyc(1);
        check("paused_point", score, 0);
        frames(10);
        check("paused_steps", step_count, 0);
        press_pause();
        check("resume_state", state, 2);
        frame();
        check("resume_step1", step_count, 0);
        frame();
        check("resume_step2", step_count, 1);

        // Score to 5, then collision + point together.
        for (int i = 0; i < 5; i++) begin
            point = 1'b1; cyc(1); point = 1'b0; cyc(1);
        end
        check("score5", score, 5);
        collision = 1'b1; point = 1'b1; cyc(1);
        collision = 1'b0; point = 1'b0; cyc(1);
        check("cp_score", score, 6);
        check("cp_lives", lives, 2);
        check("cp_state", state, 4);
        check("cp_frames", frames_left, 60);
        collision = 1'b1; cyc(1); collision = 1'b0; cyc(1);
        check("resp_coll_ignored", lives, 2);
        frames(60);
        check("resp_done", state, 2);

        // Two more collisions: lives 1 then 0 and game over.
        collision = 1'b1; cyc(1); collision = 1'b0; cyc(1);
        check("hit2_lives", lives, 1);
        check("hit2_state", state, 4);
        frames(60);
        check("hit2_play", state, 2);
        collision = 1'b1; pause = 1'b1; cyc(1);
        collision = 1'b0; cyc(1); pause = 1'b0; cyc(1);
        check("over_lives", lives, 0);
        check("over_state", state, 5);
        check("over_gameon", gameon, 0);
        check("over_freeze", freeze, 1);
        check("over_score", score, 6);

        // Restart from OVER, build score 0x1234, reset during respawn.
        press_start();
        check("restart_state", state, 1);
        check("restart_lives", lives, 3);
        check("restart_score", score, 0);
        frames(180);
        check("restart_play", state, 2);
        point = 1'b1; cyc(16'h1234); point = 1'b0; cyc(1);
        check("score_1234", score, 16'h1234);
        collision = 1'b1; cyc(1); collision = 1'b0; cyc(1);
        frames(5);
        check("resp_frames", frames_left, 55);
        reset = 1'b1; cyc(1);
        check("rst2_state", state, 0);
        check("rst2_score", score, 0);
        check("rst2_lives", lives, 3);
        check("rst2_frames", frames_left, 0);
        check("rst2_step", step, 0);
        reset = 1'b0; cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
